// File: rtl/bf_apod_sum_if.sv
// Handshake and data bundle between the apodised delay-and-sum engine, delay_con and the line buffer.
// The slave modport is the engine's view of the bundle; the master modport is the surrounding system's view.
interface bf_apod_sum_if #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 16,
    parameter int COEF_WIDTH   = 8,
    parameter int OUT_WIDTH    = 16
);
    logic                               start;
    logic                               abort;
    logic [NUM_CHANNELS*COEF_WIDTH-1:0] apod_flat;
    logic                               delay_start;
    logic                               delay_ready;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] delayed_flat;
    logic [OUT_WIDTH-1:0]               sum_out;
    logic                               sum_valid;
    logic                               sum_ready;
    logic                               busy;
    logic                               sat_flag;

    modport master (
        output start, abort, apod_flat, delay_ready, delayed_flat, sum_ready,
        input  delay_start, sum_out, sum_valid, busy, sat_flag
    );

    modport slave (
        input  start, abort, apod_flat, delay_ready, delayed_flat, sum_ready,
        output delay_start, sum_out, sum_valid, busy, sat_flag
    );
endinterface

// File: rtl/bf_apod_sum.sv
// Apodised delay-and-sum for one focal point: snapshot delayed samples, weight them, accumulate
// LANES channels per cycle, then scale/saturate into one output sample on a valid/ready handshake.
module bf_apod_sum #(
    parameter int DATA_WIDTH   = 16,
    parameter int NUM_CHANNELS = 16,
    parameter int LANES        = 4,
    parameter int COEF_WIDTH   = 8,
    parameter int OUT_WIDTH    = 16,
    parameter int SATURATE     = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    bf_apod_sum_if.slave bus
);
    localparam int G      = NUM_CHANNELS / LANES;
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W  = PROD_W + $clog2(NUM_CHANNELS);
    localparam int GRP_W  = $clog2(G + 1);

    localparam logic [GRP_W-1:0] G_LAST = GRP_W'(G);
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DELAY = 2'd1,
        ACCUM      = 2'd2,
        OUTPUT     = 2'd3
    } state_t;

    state_t                             state_r;
    logic [NUM_CHANNELS*COEF_WIDTH-1:0] w_r;
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] snap_r;
    logic signed [ACC_W-1:0]            acc_r;
    logic [GRP_W-1:0]                   grp_r;
    logic                               delay_start_r;
    logic                               sum_valid_r;
    logic                               busy_r;
    logic                               sat_flag_r;
    logic [OUT_WIDTH-1:0]               sum_out_r;

    logic signed [ACC_W-1:0]            lane_sum_s;
    logic signed [ACC_W-1:0]            shifted_s;
    logic [OUT_WIDTH-1:0]               result_s;
    logic                               clamp_s;

    // Weighted sum of the LANES channels in the current group; group index is held in range past the last group.
    always_comb begin : lane_sum_blk
        logic signed [PROD_W-1:0] prod_v;
        int                       base_v;
        lane_sum_s = {ACC_W{1'b0}};
        prod_v     = {PROD_W{1'b0}};
        base_v     = 0;
        if (grp_r < G_LAST) begin
            base_v = int'(grp_r) * LANES;
        end else begin
            base_v = 0;
        end
        for (int i = 0; i < LANES; i++) begin
            prod_v = $signed(snap_r[(base_v+i)*DATA_WIDTH +: DATA_WIDTH]) *
                     $signed(w_r[(base_v+i)*COEF_WIDTH +: COEF_WIDTH]);
            lane_sum_s = lane_sum_s + ACC_W'(prod_v);
        end
    end

    // Drop the Q1.(COEF_WIDTH-1) fraction with an arithmetic shift (floor), then clamp or wrap.
    always_comb begin
        shifted_s = acc_r >>> (COEF_WIDTH - 1);
        clamp_s   = 1'b0;
        result_s  = shifted_s[OUT_WIDTH-1:0];
        if (SATURATE != 0) begin
            if (shifted_s > OUT_MAX) begin
                clamp_s  = 1'b1;
                result_s = OUT_MAX[OUT_WIDTH-1:0];
            end else if (shifted_s < OUT_MIN) begin
                clamp_s  = 1'b1;
                result_s = OUT_MIN[OUT_WIDTH-1:0];
            end else begin
                clamp_s  = 1'b0;
                result_s = shifted_s[OUT_WIDTH-1:0];
            end
        end else begin
            clamp_s  = 1'b0;
            result_s = shifted_s[OUT_WIDTH-1:0];
        end
    end

    // Control FSM with all datapath registers and registered outputs; abort overrides every transition.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= IDLE;
            w_r           <= {(NUM_CHANNELS*COEF_WIDTH){1'b0}};
            snap_r        <= {(NUM_CHANNELS*DATA_WIDTH){1'b0}};
            acc_r         <= {ACC_W{1'b0}};
            grp_r         <= {GRP_W{1'b0}};
            delay_start_r <= 1'b0;
            sum_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
            sat_flag_r    <= 1'b0;
            sum_out_r     <= {OUT_WIDTH{1'b0}};
        end else begin
            delay_start_r <= 1'b0;
            if (bus.abort) begin
                state_r     <= IDLE;
                sum_valid_r <= 1'b0;
                busy_r      <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (bus.start) begin
                            w_r           <= bus.apod_flat;
                            sat_flag_r    <= 1'b0;
                            delay_start_r <= 1'b1;
                            busy_r        <= 1'b1;
                            state_r       <= WAIT_DELAY;
                        end
                    end
                    WAIT_DELAY: begin
                        if (bus.delay_ready) begin
                            snap_r  <= bus.delayed_flat;
                            acc_r   <= {ACC_W{1'b0}};
                            grp_r   <= {GRP_W{1'b0}};
                            state_r <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        if (grp_r == G_LAST) begin
                            sum_out_r   <= result_s;
                            sum_valid_r <= 1'b1;
                            state_r     <= OUTPUT;
                            if (clamp_s) begin
                                sat_flag_r <= 1'b1;
                            end
                        end else begin
                            acc_r <= acc_r + lane_sum_s;
                            grp_r <= grp_r + GRP_W'(1);
                        end
                    end
                    OUTPUT: begin
                        // sum_valid is always high here, so sum_ready alone completes the handshake.
                        if (bus.sum_ready) begin
                            sum_valid_r <= 1'b0;
                            if (bus.start) begin
                                w_r           <= bus.apod_flat;
                                sat_flag_r    <= 1'b0;
                                delay_start_r <= 1'b1;
                                state_r       <= WAIT_DELAY;
                            end else begin
                                busy_r  <= 1'b0;
                                state_r <= IDLE;
                            end
                        end
                    end
                    default: begin
                        state_r     <= IDLE;
                        sum_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.delay_start = delay_start_r;
    assign bus.sum_valid   = sum_valid_r;
    assign bus.sum_out     = sum_out_r;
    assign bus.busy        = busy_r;
    assign bus.sat_flag    = sat_flag_r;
endmodule
